// File: rtl/mem_responder_if.sv
// Request/response bundle between the multicycle MIPS control path and the
// memory responder. The controller side is the master, memory is the slave.
interface mem_responder_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              ReqValid;
    logic              ReqWrite;
    logic [ADDR_W-1:0] Addr;
    logic [DATA_W-1:0] WrData;
    logic [DATA_W-1:0] RdData;
    logic              RspValid;
    logic              Busy;
    logic              AddrErr;
    logic [7:0]        DropCnt;

    modport master (
        output ReqValid, ReqWrite, Addr, WrData,
        input  RdData, RspValid, Busy, AddrErr, DropCnt
    );

    modport slave (
        input  ReqValid, ReqWrite, Addr, WrData,
        output RdData, RspValid, Busy, AddrErr, DropCnt
    );
endinterface

// File: rtl/mem_responder.sv
// Word-organised RAM responder with a fixed read latency, so the controller's
// hard-coded wait states line up with the data arriving in RdData.
module mem_responder #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int READ_LAT    = 2
) (
    input  logic            Clock,
    input  logic            Reset,
    mem_responder_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_DONE = 2'd2,
        WR_ACK  = 2'd3
    } state_t;

    // The range test uses the whole word index, so high address bits never alias.
    function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
        return (a[1:0] != 2'b00) ||
               ({2'b00, a[ADDR_W-1:2]} >= ADDR_W'(DEPTH_WORDS));
    endfunction

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]  rd_data_q, rd_data_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               busy_q, busy_d;
    logic               addr_err_q, addr_err_d;
    logic [7:0]         drop_cnt_q, drop_cnt_d;
    logic               mem_we_s;
    logic [IDX_W-1:0]   req_idx_s;
    logic [DATA_W-1:0]  mem_q [DEPTH_WORDS];

    assign req_idx_s = bus.Addr[IDX_W+1:2];

    // Next-state, memory strobe and next-output decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        rd_data_d  = rd_data_q;
        addr_err_d = 1'b0;
        drop_cnt_d = drop_cnt_q;
        mem_we_s   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.ReqValid) begin
                    if (addr_bad(bus.Addr)) begin
                        addr_err_d = 1'b1;
                    end else if (bus.ReqWrite) begin
                        mem_we_s = 1'b1;
                        state_d  = WR_ACK;
                    end else begin
                        idx_d   = req_idx_s;
                        cnt_d   = 4'(READ_LAT);
                        state_d = RD_WAIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RD_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    rd_data_d = mem_q[idx_q];
                    state_d   = RD_DONE;
                end else begin
                    state_d = RD_WAIT;
                end
            end
            RD_DONE: state_d = IDLE;
            WR_ACK:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Any request seen outside IDLE is dropped and counted.
        if (bus.ReqValid && (state_q != IDLE)) begin
            drop_cnt_d = (drop_cnt_q == 8'hFF) ? drop_cnt_q : drop_cnt_q + 8'd1;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end

        rsp_valid_d = (state_d == RD_DONE) || (state_d == WR_ACK);
        busy_d      = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            idx_q       <= '0;
            rd_data_q   <= '0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            addr_err_q  <= 1'b0;
            drop_cnt_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            rd_data_q   <= rd_data_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
            addr_err_q  <= addr_err_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // RAM array; contents survive Reset, but a store coinciding with Reset is dropped.
    always_ff @(posedge Clock) begin
        if (Reset && mem_we_s) begin
            mem_q[req_idx_s] <= bus.WrData;
        end
    end

    assign bus.RdData   = rd_data_q;
    assign bus.RspValid = rsp_valid_q;
    assign bus.Busy     = busy_q;
    assign bus.AddrErr  = addr_err_q;
    assign bus.DropCnt  = drop_cnt_q;
endmodule

// File: tb/tb_mem_responder.sv
// Random and directed stimulus for mem_responder, checked every cycle against
// a transaction-level model built on edge numbers and a word array.
module tb_mem_responder;
    localparam int LAT = 2;

    logic Clock;
    logic Reset;

    mem_responder_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_responder #(
        .ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(256), .READ_LAT(LAT)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    int n_vec  = 0;
    int n_miss = 0;

    // Model: edge numbers at which things happen, rather than FSM states.
    int          edge_n    = 0;
    int          free_edge = 0;
    int          rsp_edge  = -1;
    logic        rsp_rd    = 1'b0;
    logic [31:0] pend      = 32'd0;
    logic [31:0] m_rd      = 32'd0;
    logic [7:0]  m_drop    = 8'd0;
    logic        m_err     = 1'b0;
    logic [31:0] m_mem [256];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    task automatic model_edge(input logic rst, input logic rv, input logic rw,
                              input logic [31:0] a, input logic [31:0] wd);
        edge_n++;
        m_err = 1'b0;
        if (!rst) begin
            free_edge = edge_n + 1;
            rsp_edge  = -1;
            m_rd      = 32'd0;
            m_drop    = 8'd0;
        end else begin
            if (rv) begin
                if (edge_n < free_edge) begin
                    if (m_drop != 8'd255) m_drop++;
                end else if (a[1:0] != 2'b00 || a[31:2] >= 30'd256) begin
                    m_err = 1'b1;
                end else if (rw) begin
                    m_mem[a[9:2]] = wd;
                    rsp_edge  = edge_n;
                    rsp_rd    = 1'b0;
                    free_edge = edge_n + 2;
                end else begin
                    pend      = m_mem[a[9:2]];
                    rsp_edge  = edge_n + LAT;
                    rsp_rd    = 1'b1;
                    free_edge = edge_n + LAT + 2;
                end
            end
            if (rsp_edge == edge_n && rsp_rd) m_rd = pend;
        end
    endtask

    task automatic step(input logic rst, input logic rv, input logic rw,
                        input logic [31:0] a, input logic [31:0] wd);
        Reset        = rst;
        bus.ReqValid = rv;
        bus.ReqWrite = rw;
        bus.Addr     = a;
        bus.WrData   = wd;
        @(posedge Clock);
        model_edge(rst, rv, rw, a, wd);
        #1;
        chk("rsp_valid", {31'd0, bus.RspValid}, {31'd0, (rsp_edge == edge_n)});
        chk("busy",      {31'd0, bus.Busy},     {31'd0, (edge_n + 1 < free_edge)});
        chk("addr_err",  {31'd0, bus.AddrErr},  {31'd0, m_err});
        chk("drop_cnt",  {24'd0, bus.DropCnt},  {24'd0, m_drop});
        chk("rd_data",   bus.RdData,            m_rd);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] wd;
        int          r;

        Reset = 1'b0;
        bus.ReqValid = 1'b0;
        bus.ReqWrite = 1'b0;
        bus.Addr     = 32'd0;
        bus.WrData   = 32'd0;

        // Reset for two cycles, then release.
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        idle(1);

        // Fill the whole array so every later read has a known value.
        for (int i = 0; i < 256; i++) begin
            step(1'b1, 1'b1, 1'b1, 32'(i * 4), $urandom);
            idle(1);
        end

        // Write then read back 0x10.
        step(1'b1, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
        idle(1);
        step(1'b1, 1'b1, 1'b0, 32'h10, 32'd0);
        idle(LAT + 1);
        chk("plan_rd_10", bus.RdData, 32'hDEADBEEF);

        // Two writes, then back-to-back reads at the first IDLE cycle.
        step(1'b1, 1'b1, 1'b1, 32'h0, 32'h11223344);
        idle(1);
        step(1'b1, 1'b1, 1'b1, 32'h4, 32'h55667788);
        idle(1);
        step(1'b1, 1'b1, 1'b0, 32'h4, 32'd0);
        idle(LAT + 1);
        chk("plan_rd_4", bus.RdData, 32'h55667788);
        step(1'b1, 1'b1, 1'b0, 32'h0, 32'd0);
        idle(LAT + 1);
        chk("plan_rd_0", bus.RdData, 32'h11223344);
        chk("plan_drop0", {24'd0, bus.DropCnt}, 32'd0);

        // Misaligned and out-of-range requests.
        step(1'b1, 1'b1, 1'b0, 32'h6, 32'd0);
        idle(1);
        step(1'b1, 1'b1, 1'b0, 32'h400, 32'd0);
        idle(2);

        // Requests during RD_WAIT and RD_DONE are dropped.
        step(1'b1, 1'b1, 1'b0, 32'h10, 32'd0);
        step(1'b1, 1'b1, 1'b1, 32'h10, 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'h10, 32'd0);
        step(1'b1, 1'b1, 1'b1, 32'h10, 32'd0);
        idle(1);
        chk("plan_drop2", {24'd0, bus.DropCnt}, 32'd2);
        chk("plan_rd_keep", bus.RdData, 32'hDEADBEEF);
        step(1'b1, 1'b1, 1'b0, 32'h10, 32'd0);
        idle(LAT + 1);
        chk("plan_mem_keep", bus.RdData, 32'hDEADBEEF);

        // Reset in the middle of a read, then read again.
        step(1'b1, 1'b1, 1'b0, 32'h10, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        idle(3);
        chk("plan_rst_rd", bus.RdData, 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'h10, 32'd0);
        idle(LAT + 1);
        chk("plan_rst_mem", bus.RdData, 32'hDEADBEEF);

        // Continuous requests drive DropCnt into saturation.
        for (int i = 0; i < 400; i++) begin
            step(1'b1, 1'b1, 1'b0, {22'd0, 8'($urandom), 2'b00}, 32'd0);
        end
        idle(LAT + 2);
        chk("drop_sat", {24'd0, bus.DropCnt}, 32'd255);

        // Random traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            r  = int'($urandom_range(0, 9));
            wd = $urandom;
            if (r < 7)       a = {22'd0, 8'($urandom), 2'b00};
            else if (r == 7) a = {22'd0, 8'($urandom), 2'($urandom_range(1, 3))};
            else if (r == 8) a = 32'h400 + {20'd0, 10'($urandom), 2'b00};
            else             a = $urandom;
            step(($urandom_range(0, 99) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), a, wd);
        end
        idle(LAT + 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
